// File: rtl/bit_serial_alu_if.sv
// bit_serial_alu_if
// Groups the request and completion signals between a controller and the
// bit-serial ALU.
//
// Handshake: the controller raises start with op/a/b valid in the same cycle.
// The ALU accepts the request only when idle (busy=0). That includes the
// cycle in which done is high. Once a request is accepted, busy stays high
// until completion, and start is ignored during that time. done pulses for
// exactly one cycle. result/carry_out/zero are valid from that cycle and are
// held until the next completion.
//
// Signals:
//   start     controller -> alu  request a new operation
//   op[2:0]   controller -> alu  opcode
//   a, b      controller -> alu  operands, WIDTH bits each
//   busy      alu -> controller  operation in progress
//   done      alu -> controller  one-cycle completion pulse
//   result    alu -> controller  last completed result
//   carry_out alu -> controller  final carry of ADD/SUB, 0 for logic ops
//   zero      alu -> controller  result == 0
interface bit_serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, zero
  );
endinterface

// File: rtl/bit_serial_alu.sv
// bit_serial_alu
// Multi-cycle ALU that evaluates one bit per clock, starting at the LSB.
// It supports AND, OR, NAND, NOR, ADD and SUB. A single full adder serves
// ADD and SUB, and the carry is held in a register between bits. SUB is
// computed as A + ~B + 1.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high; has priority over start
//   bus        bit_serial_alu_if.slave (start/op/a/b in;
//              busy/done/result/carry_out/zero out)
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN)
//
// Timing: when start is accepted at edge E0, bit k is processed at edge
// E0+1+k. The last bit is processed at edge E0+WIDTH, which also raises done
// for the following cycle.
module bit_serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  bit_serial_alu_if.slave    bus,
  output logic               dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [WIDTH-1:0] r_res_sh;
  logic [CW-1:0]    r_cnt;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_zero;

  logic             w_is_sub;
  logic             w_is_logic;
  logic             w_b_eff;
  logic             w_sum;
  logic             w_carry_nxt;
  logic             w_bit;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // Per-bit datapath. Logic ops use the raw b bit. Only the adder sees the
  // inverted b bit for SUB.
  always_comb begin
    w_is_sub    = (r_op == 3'b110);
    w_b_eff     = w_is_sub ? ~r_b[0] : r_b[0];
    w_sum       = r_a[0] ^ w_b_eff ^ r_carry;
    w_carry_nxt = (r_a[0] & w_b_eff) | ((r_a[0] ^ w_b_eff) & r_carry);
    w_is_logic  = 1'b1;
    w_bit       = 1'b0;
    case (r_op)
      3'b000:  w_bit = r_a[0] & r_b[0];
      3'b001:  w_bit = r_a[0] | r_b[0];
      3'b011:  w_bit = ~(r_a[0] & r_b[0]);
      3'b100:  w_bit = ~(r_a[0] | r_b[0]);
      default: begin
        // 010 ADD and 110 SUB. The undefined codes 101 and 111 behave as ADD
        // because w_is_sub is low for them.
        w_bit      = w_sum;
        w_is_logic = 1'b0;
      end
    endcase
    w_res_nxt = {w_bit, r_res_sh[WIDTH-1:1]};
    w_last    = (r_cnt == CW'(WIDTH - 1));
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_res_sh    <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_op     <= bus.op;
            r_carry  <= (bus.op == 3'b110);
            r_res_sh <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_carry  <= w_carry_nxt;
          r_res_sh <= w_res_nxt;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_result    <= w_res_nxt;
            r_carry_out <= w_is_logic ? 1'b0 : w_carry_nxt;
            r_zero      <= (w_res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.zero      = r_zero;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed testbench for bit_serial_alu with WIDTH=8.
module tb_bit_serial_alu;

  localparam int W = 8;

  logic clk;
  logic reset;
  logic dbg_state;

  bit_serial_alu_if #(.WIDTH(W)) bus ();

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Drive a request at a negedge and let the next posedge (E0) sample it.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Call this right after E0. It samples at each negedge.
  // edges      = active edges from E0 until done is seen (99 = timeout)
  // busy_cnt   = cycles with busy high before done
  // stable     = result did not change while the operation was running
  task automatic wait_done(output int edges, output int busy_cnt,
                           output logic stable);
    logic [W-1:0] prev;
    prev     = bus.result;
    edges    = 99;
    busy_cnt = 0;
    stable   = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        edges = n - 1;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.result !== prev) stable = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else n_pass++;
    n_total++; if (bus.result !== 8'h00) $display("FAIL reset_result got=%h exp=00", bus.result); else n_pass++;
    n_total++; if (bus.carry_out !== 1'b0) $display("FAIL reset_carry got=%b exp=0", bus.carry_out); else n_pass++;
    n_total++; if (bus.zero !== 1'b0) $display("FAIL reset_zero got=%b exp=0", bus.zero); else n_pass++;
    n_total++; if (dbg_state !== 1'b0) $display("FAIL reset_state got=%b exp=0", dbg_state); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_add();
    int edges, busy_cnt;
    logic stable;
    issue(3'b010, 8'hFF, 8'h01);
    wait_done(edges, busy_cnt, stable);
    n_total++; if (edges !== 8) $display("FAIL add_latency got=%0d exp=8", edges); else n_pass++;
    n_total++; if (busy_cnt !== 8) $display("FAIL add_busy_cycles got=%0d exp=8", busy_cnt); else n_pass++;
    n_total++; if (stable !== 1'b1) $display("FAIL add_result_stable got=%b exp=1", stable); else n_pass++;
    n_total++; if (bus.result !== 8'h00) $display("FAIL add_result got=%h exp=00", bus.result); else n_pass++;
    n_total++; if (bus.carry_out !== 1'b1) $display("FAIL add_carry got=%b exp=1", bus.carry_out); else n_pass++;
    n_total++; if (bus.zero !== 1'b1) $display("FAIL add_zero got=%b exp=1", bus.zero); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.done !== 1'b0) $display("FAIL add_done_pulse got=%b exp=0", bus.done); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL add_idle_busy got=%b exp=0", bus.busy); else n_pass++;
  endtask

  task automatic test_sub();
    int edges, busy_cnt;
    logic stable;
    issue(3'b110, 8'h07, 8'h05);
    wait_done(edges, busy_cnt, stable);
    n_total++; if (edges !== 8) $display("FAIL sub1_latency got=%0d exp=8", edges); else n_pass++;
    n_total++; if (bus.result !== 8'h02) $display("FAIL sub1_result got=%h exp=02", bus.result); else n_pass++;
    n_total++; if (bus.carry_out !== 1'b1) $display("FAIL sub1_carry got=%b exp=1", bus.carry_out); else n_pass++;
    n_total++; if (bus.zero !== 1'b0) $display("FAIL sub1_zero got=%b exp=0", bus.zero); else n_pass++;
    issue(3'b110, 8'h05, 8'h07);
    wait_done(edges, busy_cnt, stable);
    n_total++; if (bus.result !== 8'hFE) $display("FAIL sub2_result got=%h exp=fe", bus.result); else n_pass++;
    n_total++; if (bus.carry_out !== 1'b0) $display("FAIL sub2_carry got=%b exp=0", bus.carry_out); else n_pass++;
    n_total++; if (bus.zero !== 1'b0) $display("FAIL sub2_zero got=%b exp=0", bus.zero); else n_pass++;
  endtask

  task automatic test_logic();
    logic [2:0] ops [4];
    logic [W-1:0] exp_r [4];
    int edges, busy_cnt;
    logic stable;
    ops[0] = 3'b000; exp_r[0] = 8'hC0;
    ops[1] = 3'b001; exp_r[1] = 8'hFC;
    ops[2] = 3'b011; exp_r[2] = 8'h3F;
    ops[3] = 3'b100; exp_r[3] = 8'h03;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 8'hF0, 8'hCC);
      wait_done(edges, busy_cnt, stable);
      n_total++; if (bus.result !== exp_r[i]) $display("FAIL logic_result op=%b got=%h exp=%h", ops[i], bus.result, exp_r[i]); else n_pass++;
      n_total++; if (bus.carry_out !== 1'b0) $display("FAIL logic_carry op=%b got=%b exp=0", ops[i], bus.carry_out); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int edges, busy_cnt;
    logic stable;
    int done_n;
    issue(3'b010, 8'h10, 8'h20);
    done_n = 99;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_n = n - 1;
        break;
      end
      // This request arrives while busy and must be ignored.
      if (n == 3) begin
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 8'hFF; bus.b = 8'h0F;
      end else begin
        bus.start = 1'b0;
      end
    end
    n_total++; if (done_n !== 8) $display("FAIL ignore_latency got=%0d exp=8", done_n); else n_pass++;
    n_total++; if (bus.result !== 8'h30) $display("FAIL ignore_result got=%h exp=30", bus.result); else n_pass++;
    n_total++; if (bus.carry_out !== 1'b0) $display("FAIL ignore_carry got=%b exp=0", bus.carry_out); else n_pass++;
    // Issue a new request in the done cycle. It should be accepted immediately.
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 8'h09; bus.b = 8'h04;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(edges, busy_cnt, stable);
    n_total++; if (edges !== 8) $display("FAIL b2b_latency got=%0d exp=8", edges); else n_pass++;
    n_total++; if (bus.result !== 8'h05) $display("FAIL b2b_result got=%h exp=05", bus.result); else n_pass++;
    n_total++; if (bus.carry_out !== 1'b1) $display("FAIL b2b_carry got=%b exp=1", bus.carry_out); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int edges, busy_cnt;
    logic stable;
    int seen_done;
    issue(3'b010, 8'h11, 8'h22);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.result !== 8'h00) $display("FAIL midrst_result got=%h exp=00", bus.result); else n_pass++;
    n_total++; if (bus.zero !== 1'b0) $display("FAIL midrst_zero got=%b exp=0", bus.zero); else n_pass++;
    reset = 1'b0;
    seen_done = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done++;
    end
    n_total++; if (seen_done !== 0) $display("FAIL midrst_no_done got=%0d exp=0", seen_done); else n_pass++;
    issue(3'b010, 8'h21, 8'h12);
    wait_done(edges, busy_cnt, stable);
    n_total++; if (edges !== 8) $display("FAIL midrst_after_latency got=%0d exp=8", edges); else n_pass++;
    n_total++; if (bus.result !== 8'h33) $display("FAIL midrst_after_result got=%h exp=33", bus.result); else n_pass++;
  endtask

  task automatic test_undef_op();
    int edges, busy_cnt;
    logic stable;
    issue(3'b101, 8'h03, 8'h04);
    wait_done(edges, busy_cnt, stable);
    n_total++; if (bus.result !== 8'h07) $display("FAIL op101_result got=%h exp=07", bus.result); else n_pass++;
    n_total++; if (bus.carry_out !== 1'b0) $display("FAIL op101_carry got=%b exp=0", bus.carry_out); else n_pass++;
    issue(3'b111, 8'h80, 8'h80);
    wait_done(edges, busy_cnt, stable);
    n_total++; if (bus.result !== 8'h00) $display("FAIL op111_result got=%h exp=00", bus.result); else n_pass++;
    n_total++; if (bus.carry_out !== 1'b1) $display("FAIL op111_carry got=%b exp=1", bus.carry_out); else n_pass++;
    n_total++; if (bus.zero !== 1'b1) $display("FAIL op111_zero got=%b exp=1", bus.zero); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_reset_mid_run();
    test_undef_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bit_serial_alu.md
Name: bit_serial_alu

Overview:
- Multi-cycle, bit-serial ALU. Accepts a WIDTH-bit operand pair and an opcode, then evaluates one bit per clock, LSB first.
- Each bit uses the same per-bit function set as the single-bit slice: AND, OR, NAND, NOR, and a ripple full-adder for ADD/SUB. The carry is held in a register between cycles.
- Sits between the controller and the register file as an area-cheap alternative to the parallel ALU. It uses a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits. Legal range 2..64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when idle.
- op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 NAND, 100 NOR; 101 and 111 are treated as ADD.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  last completed result; held until the next completion.
- carry_out  output  1  final carry of ADD/SUB; 0 for logic ops.
- zero  output  1  high when result equals 0.

Behaviour:
- Reset: in the same edge where reset=1, state becomes IDLE.
  - busy, done, result, carry_out and zero all become 0.
  - Internal operand and counter registers are cleared.
  - reset takes priority over start.
- States: IDLE and RUN.
- IDLE:
  - If start=1 at an edge: capture a, b, op into shift registers, clear the bit counter, go to RUN, and busy=1 from the next cycle.
  - carry register initialisation: set to 1 if op=110 (SUB); otherwise 0.
- RUN: at each edge, operate on bit0 of the A/B shift registers.
  - b_eff = ~b0 if op=110, otherwise b0.
  - Logic ops use the un-inverted b0.
  - sum = a0 ^ b_eff ^ carry.
  - New carry = (a0 & b_eff) | ((a0 ^ b_eff) & carry).
  - Selected bit enters the MSB of the result shift register, and all shift registers shift right by 1. The counter increments.
- Completion: on the edge that processes bit WIDTH-1:
  - Go to IDLE; busy=0 and done=1 for exactly one cycle.
  - Load result from the shift register, including the bit just computed.
  - carry_out = final carry for ADD/SUB (also for 101/111); 0 for logic ops.
  - zero = (result == 0).
- Latency: if start is sampled at edge E0, done is high in the cycle after edge E0+WIDTH. Throughput is one op per WIDTH+1 cycles when start is held high continuously.
- start while busy=1 is ignored: no capture, no effect on the operation in flight.
- start in the done cycle is accepted, since the block is already IDLE.
- Output stability: result, carry_out and zero change only on completion or reset. They are not updated mid-run.
- SUB semantics: carry_out=1 means no borrow (A >= B unsigned).
- Overflow: wraps modulo 2^WIDTH; no overflow flag.
- Reset mid-run aborts the operation: done is never asserted for it, and outputs go to 0.

Test Plan (WIDTH=8):
- ADD a=0xFF, b=0x01, start pulse → busy high for 8 cycles; done high exactly 8 edges after start; result=0x00, carry_out=1, zero=1.
- SUB a=0x07, b=0x05 → result=0x02, carry_out=1, zero=0. SUB a=0x05, b=0x07 → result=0xFE, carry_out=0.
- Logic ops with a=0xF0, b=0xCC:
  - AND → 0xC0; OR → 0xFC; NAND → 0x3F; NOR → 0x03.
  - carry_out=0 in all four cases.
- ADD 0x10+0x20 in flight, start asserted at cycle 3 with op=AND and different operands → ignored; result=0x30 and the next op is unaffected. Back-to-back start in the done cycle → second op completes 8 edges later.
- Reset asserted at cycle 4 of a run → next cycle busy=0, result=0, zero=0; no done pulse follows. A new start then completes normally.
- Undefined op=101 with a=0x03, b=0x04 → result=0x07, treated as ADD.
